// File: rtl/sdp_x_alu_core_cfg_shift_value_rsci_ctrl_if.sv
// Handshake bundle between the config side, the ALU core and the triosy wait datapath
// for the shift-value channel.
interface sdp_x_alu_core_cfg_shift_value_rsci_ctrl_if #(
  parameter int unsigned DW = 6,
  parameter int unsigned CW = 8
);
  logic          cfg_shift_vld;
  logic          cfg_shift_rdy;
  logic [DW-1:0] cfg_shift_dat;
  logic          core_rd;
  logic          core_stall;
  logic [DW-1:0] core_dat;
  logic          core_bawt;
  logic          triosy_biwt;
  logic          triosy_bdwt;
  logic          triosy_bawt;
  logic          triosy_lz;
  logic [CW-1:0] xfer_cnt;

  modport slave (
    input  cfg_shift_vld, cfg_shift_dat, core_rd, core_stall, triosy_bawt,
    output cfg_shift_rdy, core_dat, core_bawt, triosy_biwt, triosy_bdwt,
           triosy_lz, xfer_cnt
  );

  modport master (
    output cfg_shift_vld, cfg_shift_dat, core_rd, core_stall, triosy_bawt,
    input  cfg_shift_rdy, core_dat, core_bawt, triosy_biwt, triosy_bdwt,
           triosy_lz, xfer_cnt
  );
endinterface

// File: rtl/sdp_x_alu_core_cfg_shift_value_rsci_ctrl.sv
// Shift-value feeder: 2-entry skid FIFO toward the ALU core plus the triosy
// completion handshake and a completed-transfer counter.
module sdp_x_alu_core_cfg_shift_value_rsci_ctrl #(
  parameter int unsigned DW = 6,
  parameter int unsigned CW = 8
) (
  input  logic nvdla_core_clk,
  input  logic nvdla_core_rstn,
  sdp_x_alu_core_cfg_shift_value_rsci_ctrl_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, SIG = 1'b1} state_t;

  state_t        state;
  logic [1:0]    count;
  logic          wr_ptr;
  logic          rd_ptr;
  logic [DW-1:0] mem [2];
  logic [CW-1:0] xfer_cnt_q;

  logic push;
  logic pop;
  logic pop_ok;
  logic lz;

  // Ready depends only on registered occupancy, never on pop or downstream ack.
  assign bus.cfg_shift_rdy = (count < 2'd2);
  assign bus.core_bawt     = (count != 2'd0);
  assign bus.core_dat      = mem[rd_ptr];

  assign push   = bus.cfg_shift_vld & bus.cfg_shift_rdy;
  assign pop_ok = (state == IDLE) | ((state == SIG) & bus.triosy_bawt);
  assign pop    = bus.core_rd & ~bus.core_stall & bus.core_bawt & pop_ok;

  assign lz              = (state == SIG) & bus.triosy_bawt;
  assign bus.triosy_lz   = lz;
  assign bus.triosy_biwt = (state == SIG) & ~bus.core_stall;
  assign bus.triosy_bdwt = bus.core_stall;
  assign bus.xfer_cnt    = xfer_cnt_q;

  // FIFO storage, pointers, occupancy, triosy state and completion counter.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      mem[0]     <= '0;
      mem[1]     <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      state      <= IDLE;
      xfer_cnt_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.cfg_shift_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      case (state)
        IDLE: if (pop) state <= SIG;
        SIG:  if (bus.triosy_bawt && !pop) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (lz) begin
        xfer_cnt_q <= xfer_cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sdp_x_alu_core_cfg_shift_value_rsci_ctrl.sv
// Bench for the shift-value feeder: directed stimulus with a queue-based scoreboard
// and a negedge monitor that checks every output cycle by cycle.
module tb_sdp_x_alu_core_cfg_shift_value_rsci_ctrl;

  localparam int unsigned DW = 6;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic bawt_block = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] exp_q[$];

  // Reference model state (represents the DUT after the next rising edge).
  int            m_cnt = 0;
  logic          m_sig = 1'b0;
  logic [CW-1:0] m_x   = '0;

  sdp_x_alu_core_cfg_shift_value_rsci_ctrl_if #(.DW(DW), .CW(CW)) bus ();

  sdp_x_alu_core_cfg_shift_value_rsci_ctrl #(.DW(DW), .CW(CW)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .bus             (bus)
  );

  // Downstream wait datapath: ack follows biwt unless the bench withholds it.
  assign bus.triosy_bawt = bus.triosy_biwt & ~bawt_block;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_val(input logic [DW-1:0] d);
    logic acc;
    acc = 1'b0;
    bus.cfg_shift_vld = 1'b1;
    bus.cfg_shift_dat = d;
    exp_q.push_back(d);
    for (int k = 0; k < 50 && !acc; k++) begin
      acc = bus.cfg_shift_rdy;
      step();
    end
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
    bus.cfg_shift_vld = 1'b0;
  endtask

  task automatic do_xfer(input logic [DW-1:0] d);
    push_val(d);
    bus.core_rd = 1'b1;
    step();
    bus.core_rd = 1'b0;
    step(2);
  endtask

  // Monitor: compare DUT against the model, then advance the model with this cycle's inputs.
  always @(negedge clk) begin
    logic e_rdy, e_bawt, e_biwt, e_ack, e_lz, m_push, m_pop;
    if (!rstn) begin
      m_cnt = 0;
      m_sig = 1'b0;
      m_x   = '0;
      exp_q.delete();
    end else begin
      e_rdy  = (m_cnt < 2);
      e_bawt = (m_cnt != 0);
      e_biwt = m_sig & ~bus.core_stall;
      e_ack  = e_biwt & ~bawt_block;
      e_lz   = m_sig & e_ack;
      chk("mon_rdy",  32'(bus.cfg_shift_rdy), 32'(e_rdy));
      chk("mon_bawt", 32'(bus.core_bawt),     32'(e_bawt));
      chk("mon_biwt", 32'(bus.triosy_biwt),   32'(e_biwt));
      chk("mon_bdwt", 32'(bus.triosy_bdwt),   32'(bus.core_stall));
      chk("mon_lz",   32'(bus.triosy_lz),     32'(e_lz));
      chk("mon_xfer", 32'(bus.xfer_cnt),      32'(m_x));
      if (e_bawt) begin
        if (exp_q.size() > 0) chk("mon_core_dat", 32'(bus.core_dat), 32'(exp_q[0]));
        else                  chk("mon_core_dat_noexp", 32'd0, 32'd1);
      end
      m_push = bus.cfg_shift_vld & e_rdy;
      m_pop  = bus.core_rd & ~bus.core_stall & e_bawt & (~m_sig | e_ack);
      if (m_pop && exp_q.size() > 0) void'(exp_q.pop_front());
      m_cnt = m_cnt + int'(m_push) - int'(m_pop);
      if (e_lz) m_x = m_x + CW'(1);
      if (m_pop)      m_sig = 1'b1;
      else if (e_lz)  m_sig = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_shift_vld = 1'b0;
    bus.cfg_shift_dat = '0;
    bus.core_rd       = 1'b0;
    bus.core_stall    = 1'b0;

    // Reset then idle
    step(3);
    rstn = 1'b1;
    step();
    chk("rst_rdy",  32'(bus.cfg_shift_rdy), 32'd1);
    chk("rst_bawt", 32'(bus.core_bawt),     32'd0);
    chk("rst_dat",  32'(bus.core_dat),      32'd0);
    chk("rst_lz",   32'(bus.triosy_lz),     32'd0);
    chk("rst_xfer", 32'(bus.xfer_cnt),      32'd0);

    // Single transfer
    push_val(6'h15);
    chk("single_dat",  32'(bus.core_dat),  32'h15);
    chk("single_bawt", 32'(bus.core_bawt), 32'd1);
    bus.core_rd = 1'b1;
    step();
    bus.core_rd = 1'b0;
    chk("single_biwt", 32'(bus.triosy_biwt), 32'd1);
    chk("single_lz",   32'(bus.triosy_lz),   32'd1);
    step();
    chk("single_lz_end", 32'(bus.triosy_lz), 32'd0);
    chk("single_xfer",   32'(bus.xfer_cnt),  32'd1);

    // Full / backpressure
    push_val(6'h01);
    push_val(6'h02);
    chk("full_rdy", 32'(bus.cfg_shift_rdy), 32'd0);
    bus.cfg_shift_vld = 1'b1;
    bus.cfg_shift_dat = 6'h03;
    exp_q.push_back(6'h03);
    step(2);
    chk("full_held_rdy", 32'(bus.cfg_shift_rdy), 32'd0);
    chk("full_head",     32'(bus.core_dat),      32'h01);
    bus.core_rd = 1'b1;
    begin
      logic acc;
      acc = 1'b0;
      for (int k = 0; k < 10 && !acc; k++) begin
        acc = bus.cfg_shift_rdy;
        step();
      end
      if (!acc) chk("full_push3_timeout", 32'd0, 32'd1);
    end
    bus.cfg_shift_vld = 1'b0;
    step(6);
    bus.core_rd = 1'b0;
    step();
    chk("full_drained", 32'(bus.core_bawt), 32'd0);
    chk("full_xfer",    32'(bus.xfer_cnt),  32'd4);

    // Stall in SIG
    push_val(6'h0A);
    bus.core_rd = 1'b1;
    step();
    bus.core_rd    = 1'b0;
    bus.core_stall = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("stall_biwt", 32'(bus.triosy_biwt), 32'd0);
      chk("stall_bdwt", 32'(bus.triosy_bdwt), 32'd1);
      chk("stall_lz",   32'(bus.triosy_lz),   32'd0);
      step();
    end
    chk("stall_xfer_hold", 32'(bus.xfer_cnt), 32'd4);
    bus.core_stall = 1'b0;
    #1;
    chk("stall_rel_lz", 32'(bus.triosy_lz), 32'd1);
    step();
    chk("stall_rel_lz_end", 32'(bus.triosy_lz), 32'd0);
    chk("stall_xfer",       32'(bus.xfer_cnt),  32'd5);

    // Back-to-back
    push_val(6'h11);
    push_val(6'h22);
    bus.core_rd = 1'b1;
    step();
    chk("b2b_lz0",  32'(bus.triosy_lz), 32'd1);
    chk("b2b_dat1", 32'(bus.core_dat),  32'h22);
    step();
    chk("b2b_lz1", 32'(bus.triosy_lz), 32'd1);
    step();
    bus.core_rd = 1'b0;
    chk("b2b_lz2",  32'(bus.triosy_lz), 32'd0);
    chk("b2b_xfer", 32'(bus.xfer_cnt),  32'd7);

    // Counter wrap from a fresh reset
    rstn = 1'b0;
    step(3);
    rstn = 1'b1;
    step();
    for (int i = 0; i < 255; i++) do_xfer(DW'(i));
    chk("wrap_255", 32'(bus.xfer_cnt), 32'd255);
    do_xfer(6'h3F);
    chk("wrap_0", 32'(bus.xfer_cnt), 32'd0);

    // Async reset with FIFO full and FSM in SIG
    push_val(6'h2A);
    bus.core_rd = 1'b1;
    step();
    bus.core_rd = 1'b0;
    bawt_block  = 1'b1;
    push_val(6'h2B);
    push_val(6'h2C);
    chk("pre_rst_rdy",  32'(bus.cfg_shift_rdy), 32'd0);
    chk("pre_rst_bawt", 32'(bus.core_bawt),     32'd1);
    chk("pre_rst_lz",   32'(bus.triosy_lz),     32'd0);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_rdy",  32'(bus.cfg_shift_rdy), 32'd1);
    chk("arst_bawt", 32'(bus.core_bawt),     32'd0);
    chk("arst_dat",  32'(bus.core_dat),      32'd0);
    chk("arst_biwt", 32'(bus.triosy_biwt),   32'd0);
    chk("arst_lz",   32'(bus.triosy_lz),     32'd0);
    chk("arst_xfer", 32'(bus.xfer_cnt),      32'd0);
    bawt_block = 1'b0;
    step(2);
    rstn = 1'b1;
    step(2);
    chk("post_rst_lz",   32'(bus.triosy_lz), 32'd0);
    chk("post_rst_xfer", 32'(bus.xfer_cnt),  32'd0);
    chk("post_rst_bawt", 32'(bus.core_bawt), 32'd0);

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
